// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream boot loader for the instruction memory.
// Frame format: length (16-bit LE word count), payload bytes, then an 8-bit
// additive checksum over the payload. Words are assembled little-endian
// and written at consecutive word-aligned addresses. The CPU stays held
// in reset until a frame has loaded with a good checksum.
module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_written,
    output logic             cpu_hold
);

    typedef enum logic [2:0] {
        IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR
    } state_t;

    state_t state, state_nxt;

    logic [7:0]       len_lo;    // low length byte, held until LEN1
    logic [15:0]      len;       // word count of the current frame
    logic [1:0]       bidx;      // byte lane of the next data byte
    logic [23:0]      wbuf;      // first three bytes of the word in flight
    logic [7:0]       csum;      // running payload checksum
    logic [CNT_W-1:0] wcnt;      // words written so far

    logic        acc;
    logic [15:0] n_len;
    logic        len_bad;
    logic        last_word;

    assign acc       = in_valid && in_ready;
    assign n_len     = {in_data, len_lo};
    // A zero-length frame or one larger than the memory is rejected up front,
    // so the address can never wrap.
    assign len_bad   = (n_len == 16'd0) || ({16'd0, n_len} > 32'(DEPTH));
    assign last_word = (bidx == 2'd3) && ((32'(wcnt) + 32'd1) == {16'd0, len});

    assign words_written = wcnt;

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and state-decoded status outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        cpu_hold  = 1'b1;
        case (state)
            IDLE, DONE, ERR: begin
                done     = (state == DONE);
                err      = (state == ERR);
                cpu_hold = (state != DONE);
                if (start) state_nxt = LEN0;
            end
            LEN0: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (acc) state_nxt = LEN1;
            end
            LEN1: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (acc) state_nxt = len_bad ? ERR : DATA;
            end
            DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (acc && last_word) state_nxt = CSUM;
            end
            CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (acc) state_nxt = (in_data == csum) ? DONE : ERR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: length capture, word assembly, checksum and memory write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_lo    <= 8'd0;
            len       <= 16'd0;
            bidx      <= 2'd0;
            wbuf      <= 24'd0;
            csum      <= 8'd0;
            wcnt      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) wcnt <= '0;
                end
                LEN0: begin
                    if (acc) len_lo <= in_data;
                end
                LEN1: begin
                    if (acc) begin
                        len  <= n_len;
                        csum <= 8'd0;
                        bidx <= 2'd0;
                    end
                end
                DATA: begin
                    if (acc) begin
                        csum <= csum + in_data;
                        bidx <= bidx + 2'd1;
                        case (bidx)
                            2'd0: wbuf[7:0]   <= in_data;
                            2'd1: wbuf[15:8]  <= in_data;
                            2'd2: wbuf[23:16] <= in_data;
                            default: begin
                                mem_we    <= 1'b1;
                                mem_addr  <= 32'({wcnt, 2'b00});
                                mem_wdata <= {in_data, wbuf};
                                wcnt      <= wcnt + CNT_W'(1);
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
